// File: rtl/vga_palette_pipe_if.sv
// vga_palette_pipe_if: palette CPU port plus pixel stream in/out of the palette pipeline
interface vga_palette_pipe_if #(parameter int COLOR_W = 8);
    logic               pal_we;
    logic [3:0]         pal_addr;
    logic [COLOR_W-1:0] pal_wdata;
    logic [COLOR_W-1:0] pal_rdata;
    logic               vsync_pulse;
    logic               blink_mode;
    logic               pix_valid;
    logic [7:0]         attr;
    logic               pix_bit;
    logic               out_valid;
    logic [COLOR_W-1:0] pixel;
    logic [COLOR_W-1:0] bgcolor;
    logic [COLOR_W-1:0] fgcolor;
    logic               blink_phase;
    modport master (
        output pal_we, pal_addr, pal_wdata, vsync_pulse, blink_mode, pix_valid, attr, pix_bit,
        input  pal_rdata, out_valid, pixel, bgcolor, fgcolor, blink_phase
    );
    modport slave (
        input  pal_we, pal_addr, pal_wdata, vsync_pulse, blink_mode, pix_valid, attr, pix_bit,
        output pal_rdata, out_valid, pixel, bgcolor, fgcolor, blink_phase
    );
endinterface

// File: rtl/vga_palette_pipe.sv
// vga_palette_pipe: 16-entry programmable text palette with 2-stage pixel pipeline and frame blink
module vga_palette_pipe #(
    parameter int COLOR_W   = 8,
    parameter int BLINK_DIV = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    vga_palette_pipe_if.slave    bus
);
    localparam logic [7:0] DEF_PAL [16] = '{
        8'h00, 8'h02, 8'h10, 8'h12, 8'h80, 8'h82, 8'h90, 8'hDB,
        8'h92, 8'h03, 8'h1C, 8'h1F, 8'hE0, 8'hE3, 8'hFC, 8'hFF
    };
    logic [COLOR_W-1:0] r_pal [16];
    logic [COLOR_W-1:0] r_rdata;
    logic               r_s1_valid;
    logic [7:0]         r_s1_attr;
    logic               r_s1_bit;
    logic               r_s1_mode;
    logic               r_valid;
    logic [COLOR_W-1:0] r_pixel;
    logic [COLOR_W-1:0] r_bg;
    logic [COLOR_W-1:0] r_fg;
    logic [7:0]         r_cnt;
    logic               r_phase;
    logic [3:0]         w_bg_idx;
    logic [COLOR_W-1:0] w_bg;
    logic [COLOR_W-1:0] w_fg;
    logic               w_hide;
    logic [COLOR_W-1:0] w_pix;

    // Palette storage and registered readback; readback sees the pre-write entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) r_pal[i] <= COLOR_W'(DEF_PAL[i]);
            r_rdata <= '0;
        end else begin
            r_rdata <= r_pal[bus.pal_addr];
            if (bus.pal_we) r_pal[bus.pal_addr] <= bus.pal_wdata;
        end
    end

    // Stage 1: capture the incoming attribute/glyph sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_attr  <= '0;
            r_s1_bit   <= 1'b0;
            r_s1_mode  <= 1'b0;
        end else begin
            r_s1_valid <= bus.pix_valid;
            r_s1_attr  <= bus.attr;
            r_s1_bit   <= bus.pix_bit;
            r_s1_mode  <= bus.blink_mode;
        end
    end

    assign w_bg_idx = r_s1_mode ? {1'b0, r_s1_attr[6:4]} : r_s1_attr[7:4];
    assign w_bg     = r_pal[w_bg_idx];
    assign w_fg     = r_pal[r_s1_attr[3:0]];
    assign w_hide   = r_s1_mode & r_s1_attr[7] & r_phase;
    assign w_pix    = (r_s1_bit & ~w_hide) ? w_fg : w_bg;

    // Stage 2: palette lookup; colours hold across bubbles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pixel <= '0;
            r_bg    <= '0;
            r_fg    <= '0;
        end else begin
            r_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_pixel <= w_pix;
                r_bg    <= w_bg;
                r_fg    <= w_fg;
            end
        end
    end

    // Blink timer: counts vsync pulses, toggles phase every BLINK_DIV frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (bus.vsync_pulse) begin
            r_cnt   <= (r_cnt == 8'(BLINK_DIV - 1)) ? '0 : r_cnt + 8'd1;
            r_phase <= (r_cnt == 8'(BLINK_DIV - 1)) ? ~r_phase : r_phase;
        end
    end

    assign bus.pal_rdata   = r_rdata;
    assign bus.out_valid   = r_valid;
    assign bus.pixel       = r_pixel;
    assign bus.bgcolor     = r_bg;
    assign bus.fgcolor     = r_fg;
    assign bus.blink_phase = r_phase;
endmodule

// File: tb/tb_vga_palette_pipe.sv
// tb_vga_palette_pipe: directed and random checks of vga_palette_pipe against a frame-level model
module tb_vga_palette_pipe;
    localparam int CW = 8;
    localparam int BD = 2;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vga_palette_pipe_if #(.COLOR_W(CW)) bus();
    vga_palette_pipe #(.COLOR_W(CW), .BLINK_DIV(BD)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int checks = 0;
    int errors = 0;

    logic [7:0] m_pal [16];
    int         m_frames;
    logic       m_phase;
    logic       m_ov;
    logic [7:0] m_bg, m_fg, m_pix, m_rd;
    logic       p_valid, p_bit, p_mode;
    logic [7:0] p_attr;

    function automatic void m_reset();
        m_pal = '{8'h00, 8'h02, 8'h10, 8'h12, 8'h80, 8'h82, 8'h90, 8'hDB,
                  8'h92, 8'h03, 8'h1C, 8'h1F, 8'hE0, 8'hE3, 8'hFC, 8'hFF};
        m_frames = 0;
        m_phase  = 1'b0;
        m_ov = 1'b0; m_bg = 8'h00; m_fg = 8'h00; m_pix = 8'h00; m_rd = 8'h00;
        p_valid = 1'b0; p_bit = 1'b0; p_mode = 1'b0; p_attr = 8'h00;
    endfunction

    // Model of one clock edge: the sample taken one edge ago is coloured with the
    // palette as it stands before this edge's write, then the write and vsync apply.
    function automatic void m_edge();
        int bgi;
        if (p_valid) begin
            bgi   = p_mode ? int'(p_attr[6:4]) : int'(p_attr[7:4]);
            m_bg  = m_pal[bgi];
            m_fg  = m_pal[p_attr[3:0]];
            m_pix = (p_bit && !(p_mode && p_attr[7] && m_phase)) ? m_fg : m_bg;
        end
        m_ov = p_valid;
        m_rd = m_pal[bus.pal_addr];
        if (bus.pal_we) m_pal[bus.pal_addr] = bus.pal_wdata;
        if (bus.vsync_pulse) begin
            m_frames++;
            if (m_frames % BD == 0) m_phase = ~m_phase;
        end
        p_valid = bus.pix_valid; p_attr = bus.attr; p_bit = bus.pix_bit; p_mode = bus.blink_mode;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
        chk("pixel", 32'(bus.pixel), 32'(m_pix));
        chk("bgcolor", 32'(bus.bgcolor), 32'(m_bg));
        chk("fgcolor", 32'(bus.fgcolor), 32'(m_fg));
        chk("pal_rdata", 32'(bus.pal_rdata), 32'(m_rd));
        chk("blink_phase", 32'(bus.blink_phase), 32'(m_phase));
    endtask

    task automatic tick();
        m_edge();
        @(posedge clk);
        #1 check_all();
        @(negedge clk);
    endtask

    initial begin
        bus.pal_we = 0; bus.pal_addr = 0; bus.pal_wdata = 0; bus.vsync_pulse = 0;
        bus.blink_mode = 0; bus.pix_valid = 0; bus.attr = 0; bus.pix_bit = 0;
        m_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_pixel", 32'(bus.pixel), 32'h0);
        rst = 1'b0;

        // Stream fg then bg pixel of attr 0x1E
        bus.attr = 8'h1E; bus.pix_valid = 1; bus.pix_bit = 1; tick();
        bus.pix_bit = 0; tick();
        chk("stream_fg", 32'(bus.fgcolor), 32'hFC);
        chk("stream_bg", 32'(bus.bgcolor), 32'h02);
        chk("stream_pix1", 32'(bus.pixel), 32'hFC);
        bus.pix_valid = 0; tick();
        chk("stream_pix0", 32'(bus.pixel), 32'h02);
        tick();
        chk("stream_end", 32'(bus.out_valid), 32'h0);

        // Palette write colliding with a stage-2 lookup of the same entry
        bus.attr = 8'h40; bus.pix_bit = 0; bus.pix_valid = 1; tick();
        bus.pal_we = 1; bus.pal_addr = 4; bus.pal_wdata = 8'h55; tick();
        chk("collide_old", 32'(bus.pixel), 32'h80);
        bus.pal_we = 0; bus.pix_valid = 0; tick();
        chk("collide_new", 32'(bus.pixel), 32'h55);
        chk("readback", 32'(bus.pal_rdata), 32'h55);

        // Blink: restore entry 4 then stream attr 0xC7 in blink mode
        bus.pal_we = 1; bus.pal_wdata = 8'h80; tick();
        bus.pal_we = 0; bus.blink_mode = 1; bus.attr = 8'hC7; bus.pix_bit = 1; bus.pix_valid = 1;
        tick(); tick();
        chk("blink_show", 32'(bus.pixel), 32'hDB);
        bus.vsync_pulse = 1; tick(); tick();
        bus.vsync_pulse = 0; tick();
        chk("blink_phase1", 32'(bus.blink_phase), 32'h1);
        chk("blink_hide", 32'(bus.pixel), 32'h80);
        bus.vsync_pulse = 1; tick(); tick();
        bus.vsync_pulse = 0; tick();
        chk("blink_unhide", 32'(bus.pixel), 32'hDB);

        // Normal mode: bg index uses attr[7], never hidden
        bus.blink_mode = 0; tick(); tick();
        chk("nomode_bg", 32'(bus.bgcolor), 32'hE0);
        chk("nomode_pix0", 32'(bus.pixel), 32'hDB);
        bus.vsync_pulse = 1; tick(); tick();
        bus.vsync_pulse = 0; tick();
        chk("nomode_pix1", 32'(bus.pixel), 32'hDB);

        // Bubbles
        for (int i = 0; i < 10; i++) begin
            bus.pix_valid = i[0]; bus.attr = 8'($urandom); bus.pix_bit = 1'($urandom);
            tick();
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bus.pal_we = ($urandom_range(3) == 0);
            bus.pal_addr = 4'($urandom);
            bus.pal_wdata = 8'($urandom);
            bus.vsync_pulse = ($urandom_range(2) == 0);
            bus.blink_mode = 1'($urandom);
            bus.pix_valid = ($urandom_range(3) != 0);
            bus.attr = 8'($urandom);
            bus.pix_bit = 1'($urandom);
            tick();
        end

        // Reach blink phase 1 with a modified palette, then reset between edges
        bus.pal_we = 1; bus.pal_addr = 4; bus.pal_wdata = 8'h3C; bus.vsync_pulse = 0; tick();
        bus.pal_we = 0;
        for (int i = 0; i < 8 && !m_phase; i++) begin
            bus.vsync_pulse = 1; tick();
        end
        bus.vsync_pulse = 0; bus.pix_valid = 1; tick();
        chk("pre_rst_phase", 32'(bus.blink_phase), 32'h1);
        #2 rst = 1'b1;
        #1;
        m_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0; bus.pix_valid = 0; bus.pal_addr = 4;
        tick();
        chk("rst_palette", 32'(bus.pal_rdata), 32'h80);
        bus.pix_valid = 1; bus.attr = 8'h1E; bus.pix_bit = 1; tick();
        chk("rst_lag1", 32'(bus.out_valid), 32'h0);
        tick();
        chk("rst_lag2", 32'(bus.out_valid), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
